// File: rtl/wb_write_arbiter.sv
// Merges the pipeline writeback and queued MAC results onto the single register-file write port.
// The pipeline always wins the slot; MAC results drain from an in-order FIFO into idle slots.
module wb_write_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_waddr,
  input  logic [31:0]              pipe_wdata,
  input  logic                     mac_valid,
  output logic                     mac_ready,
  input  logic [4:0]               mac_waddr,
  input  logic [31:0]              mac_wdata,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [31:0]              pending_mask,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic [SW-1:0]    starve_q;
  logic [SW-1:0]    starve_d;
  logic             stall_q;
  logic             stall_d;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;

  logic pipe_active;
  logic fifo_empty;
  logic push;
  logic pop;

  assign pipe_active = pipe_we && (pipe_waddr != 5'd0);
  assign fifo_empty  = (count_q == '0);
  assign mac_ready   = (count_q != (AW+1)'(DEPTH));
  // x0 handshakes complete but never occupy an entry
  assign push        = mac_valid && mac_ready && (mac_waddr != 5'd0);
  assign pop         = !pipe_active && !fifo_empty;

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign pipe_stall = stall_q;
  assign fifo_count = count_q;

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_mask[addr_q[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // Starvation: pipe holds the slot while results wait; any pop or empty FIFO resets it
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if (pipe_active && !fifo_empty) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) stall_d = 1'b1;
      else                                     starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q]  <= mac_waddr;
        data_q[wr_ptr_q]  <= mac_wdata;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + AW'(1);
      end
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);

      starve_q <= starve_d;
      stall_q  <= stall_d;

      if (pipe_active) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= pipe_waddr;
        rf_wdata_q <= pipe_wdata;
      end else if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= addr_q[rd_ptr_q];
        rf_wdata_q <= data_q[rd_ptr_q];
      end else begin
        rf_we_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with DEPTH=4, STARVE_LIMIT=8.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mac_valid;
  logic        mac_ready;
  logic [4:0]  mac_waddr;
  logic [31:0] mac_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic        pipe_stall;
  logic [2:0]  fifo_count;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_we      (pipe_we),
    .pipe_waddr   (pipe_waddr),
    .pipe_wdata   (pipe_wdata),
    .mac_valid    (mac_valid),
    .mac_ready    (mac_ready),
    .mac_waddr    (mac_waddr),
    .mac_wdata    (mac_wdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask),
    .pipe_stall   (pipe_stall),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_we = we; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic set_mac(input logic v, input logic [4:0] a, input logic [31:0] d);
    mac_valid = v; mac_waddr = a; mac_wdata = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, a});
    chk({tag, "_wdata"}, rf_wdata, d);
  endtask

  task automatic chk_q(input string tag, input logic [2:0] cnt, input logic [31:0] mask, input logic rdy);
    chk({tag, "_count"}, {29'd0, fifo_count}, {29'd0, cnt});
    chk({tag, "_mask"}, pending_mask, mask);
    chk({tag, "_ready"}, {31'd0, mac_ready}, {31'd0, rdy});
  endtask

  initial begin
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mac(1'b0, 5'd0, 32'h0);
    tick();
    reset = 1'b0;
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_stall", {31'd0, pipe_stall}, 32'd0);
    chk_q("reset", 3'd0, 32'h0, 1'b1);

    // Pipeline write, one-cycle latency
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_pipe(1'b0, 5'd0, 32'h0);
    chk_wr("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
    chk_q("pipe", 3'd0, 32'h0, 1'b1);

    // Two MAC results drain into idle slots
    set_mac(1'b1, 5'd7, 32'h11);
    tick();
    chk_wr("mac_push1", 1'b0, 5'd5, 32'hDEADBEEF);
    chk_q("mac_push1", 3'd1, 32'h0000_0080, 1'b1);
    set_mac(1'b1, 5'd9, 32'h22);
    tick();
    set_mac(1'b0, 5'd0, 32'h0);
    chk_wr("mac_pop7", 1'b1, 5'd7, 32'h11);
    chk_q("mac_pop7", 3'd1, 32'h0000_0200, 1'b1);
    tick();
    chk_wr("mac_pop9", 1'b1, 5'd9, 32'h22);
    chk_q("mac_pop9", 3'd0, 32'h0, 1'b1);
    tick();
    chk_wr("mac_idle", 1'b0, 5'd9, 32'h22);

    // Starvation: pipe busy every cycle while the FIFO fills
    set_pipe(1'b1, 5'd2, 32'h100);
    set_mac(1'b1, 5'd10, 32'hA0); tick();
    set_mac(1'b1, 5'd11, 32'hA1); tick();
    set_mac(1'b1, 5'd12, 32'hA2); tick();
    set_mac(1'b1, 5'd13, 32'hA3); tick();
    chk_q("full", 3'd4, 32'h0000_3C00, 1'b0);
    set_mac(1'b1, 5'd14, 32'hBAD);
    tick(); tick(); tick(); tick();
    chk("stall_pre", {31'd0, pipe_stall}, 32'd0);
    chk_q("full_hold", 3'd4, 32'h0000_3C00, 1'b0);
    tick();
    chk("stall_pulse", {31'd0, pipe_stall}, 32'd1);
    chk_wr("stall_pipe", 1'b1, 5'd2, 32'h100);
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mac(1'b0, 5'd0, 32'h0);
    tick();
    chk("stall_end", {31'd0, pipe_stall}, 32'd0);
    chk_wr("starve_pop", 1'b1, 5'd10, 32'hA0);
    chk_q("starve_pop", 3'd3, 32'h0000_3800, 1'b1);
    tick(); tick(); tick();
    chk_wr("drain_last", 1'b1, 5'd13, 32'hA3);
    chk_q("drain_last", 3'd0, 32'h0, 1'b1);
    tick();
    chk_wr("drain_idle", 1'b0, 5'd13, 32'hA3);
    chk_q("drain_idle", 3'd0, 32'h0, 1'b1);

    // x0 destinations from both sources are no-writes
    set_pipe(1'b1, 5'd0, 32'h55);
    set_mac(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    chk_wr("x0_a", 1'b0, 5'd13, 32'hA3);
    chk_q("x0_a", 3'd0, 32'h0, 1'b1);
    tick();
    chk_wr("x0_b", 1'b0, 5'd13, 32'hA3);
    chk_q("x0_b", 3'd0, 32'h0, 1'b1);

    // Reset with entries queued
    set_pipe(1'b1, 5'd1, 32'h7);
    set_mac(1'b1, 5'd3, 32'h31); tick();
    set_mac(1'b1, 5'd3, 32'h32); tick();
    set_mac(1'b1, 5'd4, 32'h41); tick();
    chk_q("pre_reset", 3'd3, 32'h0000_0018, 1'b1);
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mac(1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_wr("mid_reset", 1'b0, 5'd0, 32'h0);
    chk("mid_reset_stall", {31'd0, pipe_stall}, 32'd0);
    chk_q("mid_reset", 3'd0, 32'h0, 1'b1);
    tick();
    chk_wr("post_reset1", 1'b0, 5'd0, 32'h0);
    tick();
    chk_wr("post_reset2", 1'b0, 5'd0, 32'h0);

    // Push and pop together at count 2 across a pointer wrap
    set_pipe(1'b1, 5'd1, 32'h9);
    set_mac(1'b1, 5'd16, 32'h116); tick();
    set_mac(1'b1, 5'd17, 32'h117); tick();
    chk_q("wrap_fill", 3'd2, 32'h0003_0000, 1'b1);
    set_pipe(1'b0, 5'd0, 32'h0);
    set_mac(1'b1, 5'd18, 32'h118); tick();
    chk_wr("wrap_16", 1'b1, 5'd16, 32'h116);
    chk_q("wrap_16", 3'd2, 32'h0006_0000, 1'b1);
    set_mac(1'b1, 5'd19, 32'h119); tick();
    chk_wr("wrap_17", 1'b1, 5'd17, 32'h117);
    set_mac(1'b1, 5'd20, 32'h120); tick();
    chk_wr("wrap_18", 1'b1, 5'd18, 32'h118);
    set_mac(1'b1, 5'd21, 32'h121); tick();
    chk_wr("wrap_19", 1'b1, 5'd19, 32'h119);
    chk_q("wrap_19", 3'd2, 32'h0030_0000, 1'b1);
    set_mac(1'b1, 5'd22, 32'h122); tick();
    chk_wr("wrap_20", 1'b1, 5'd20, 32'h120);
    chk_q("wrap_20", 3'd2, 32'h0060_0000, 1'b1);
    set_mac(1'b0, 5'd0, 32'h0); tick();
    chk_wr("wrap_21", 1'b1, 5'd21, 32'h121);
    chk_q("wrap_21", 3'd1, 32'h0040_0000, 1'b1);
    tick();
    chk_wr("wrap_22", 1'b1, 5'd22, 32'h122);
    chk_q("wrap_22", 3'd0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Merges the two writeback sources into the register file's single write port (write_reg / write_data / reg_write).
  - Main pipeline writeback (ALU/load results): fixed timing, never back-pressured.
  - Long-latency AI/MAC unit: valid/ready handshake.
- MAC results queue in a small FIFO and drain into free write-port slots.
- Exports a pending-destination mask for hazard detection.
- Raises a one-cycle stall request when MAC results are starved.

Parameters:
- DEPTH, 4, MAC result FIFO entries (power of two, >= 2)
- STARVE_LIMIT, 8, consecutive starved cycles before pipe_stall pulses (>= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- pipe_we  input  1  pipeline writeback valid
- pipe_waddr  input  5  pipeline destination register
- pipe_wdata  input  32  pipeline result
- mac_valid  input  1  MAC result valid
- mac_ready  output  1  FIFO can accept (= not full)
- mac_waddr  input  5  MAC destination register
- mac_wdata  input  32  MAC result
- rf_we  output  1  to register file reg_write
- rf_waddr  output  5  to register file write_reg
- rf_wdata  output  32  to register file write_data
- pending_mask  output  32  bit r = 1 if any FIFO entry targets xr
- pipe_stall  output  1  one-cycle request to freeze pipeline writeback
- fifo_count  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): one clock with reset high sets rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, FIFO empty, starve counter=0. Consequently fifo_count=0, pending_mask=0, mac_ready=1.
- Reset mid-operation: FIFO contents discarded; no write issues in the cycle after reset.
- Enqueue: a MAC transfer happens when mac_valid && mac_ready at a clock edge.
  - mac_waddr==0: handshake completes but the data is dropped (not enqueued).
  - mac_ready = (fifo_count != DEPTH), combinational from state only; it does not depend on a same-cycle pop.
- Slot arbitration each cycle:
  - pipe_active = pipe_we && pipe_waddr!=0. Pipe writes to x0 are treated as no write and leave the slot free.
  - If pipe_active, the pipeline wins, unconditionally, including during a pipe_stall cycle.
  - Else if the FIFO is non-empty, pop the head.
  - Else no write.
- Latency: 1 cycle. The winner is registered into rf_we/rf_waddr/rf_wdata at the next edge. rf_we=0 means rf_waddr and rf_wdata hold their previous values.
- Simultaneous push and pop: both take effect; fifo_count is unchanged.
- Push into empty FIFO: the entry is not poppable until the following cycle (no bypass).
- FIFO ordering: strict in-order; pointers wrap modulo DEPTH.
- pending_mask:
  - Combinational OR of one-hot(dest) over valid entries; bit 0 is always 0.
  - A popped entry's bit clears in the same cycle its write becomes rf_we=1.
  - Duplicate destinations are allowed; the bit stays set while any entry matches.
- Starvation counter:
  - Increments when pipe_active && FIFO non-empty.
  - Clears to 0 when the FIFO pops or is empty.
  - When the counter equals STARVE_LIMIT-1 and the increment condition holds, the counter clears and pipe_stall=1 for exactly the next cycle.
  - Upstream must hold pipe_we=0 during a pipe_stall cycle. If it does not, the pipeline still wins and starvation accounting continues.
- Ordering hazard (same register pending in FIFO and written by pipe): not resolved here. Hazard logic uses pending_mask to prevent issue.

Test Plan:
- Reset, then pipe_we=1, waddr=5, wdata=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pending_mask=0; mac_ready=1.
- Pipe idle; push MAC (waddr=7, 0x11), then (waddr=9, 0x22) on consecutive cycles -> rf writes x7=0x11 then x9=0x22, each one cycle after becoming poppable; pending_mask bits 7 and 9 set then cleared in order; fifo_count returns to 0.
- pipe_active every cycle; MAC pushes 4 entries -> fifo_count=4, mac_ready=0; a 5th mac_valid is not accepted. With STARVE_LIMIT=8, pipe_stall pulses 1 cycle after the 8th starved cycle; pipe_we=0 there -> head entry written; mac_ready=1 again.
- Pipe writes to x0 plus MAC push to x0 (wdata=0xFFFFFFFF) -> rf_we stays 0; fifo_count stays 0; pending_mask stays 0; mac_ready stays 1.
- FIFO holds 3 entries (x3, x3, x4); assert reset for 1 cycle -> all outputs zero; fifo_count=0; no rf_we afterwards.
- Push and pop in the same cycle at fifo_count=2 across a pointer wrap (after 6 total pushes) -> fifo_count stays 2; write order matches push order.
